vsa_dmem_arbiter: RTL and testbench

- Two-requester arbiter that shares one single-ported 32x5 data memory between the data ports of two VSA cores (dual-core VSA configuration).
- Grants at most one access per cycle with round-robin priority and registers the memory command.
- Tracks in-flight reads and routes each read return to the requester that issued it.

---
 rtl/vsa_dmem_arbiter.sv | 128 ++++++++++++
 tb/tb_vsa_dmem_arbiter.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vsa_dmem_arbiter.sv
// Round-robin arbiter sharing one single-ported data memory between two VSA core data ports.
// Registers the memory command and steers each read return back to the requester that issued it.
module vsa_dmem_arbiter #(
  parameter int unsigned AW      = 5,
  parameter int unsigned DW      = 5,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0,
  input  logic          wr0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          wr1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned TAG_DEPTH = MEM_LAT + 1;

  typedef struct packed {
    logic valid;
    logic owner;
  } tag_t;

  if ((MEM_LAT < 1) || (MEM_LAT > 3)) begin : gBadMemLat
    $error("vsa_dmem_arbiter: MEM_LAT=%0d is outside the supported range 1..3", MEM_LAT);
  end

  logic                         last;
  logic                         anyGnt;
  logic                         winner;
  logic                         selWr;
  logic [AW-1:0]                selAddr;
  logic [DW-1:0]                selWdata;
  tag_t                         newTag;
  tag_t                         retTag;
  tag_t [TAG_DEPTH-1:0]         tagPipe;

  // Round-robin grant: on a tie the requester that did not win last time goes first.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && req1) begin
      gnt0 = last;
      gnt1 = ~last;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

  // Winner's command and the tag it launches into the read-return pipeline.
  always_comb begin
    anyGnt       = gnt0 | gnt1;
    winner       = gnt1;
    selWr        = gnt1 ? wr1 : wr0;
    selAddr      = gnt1 ? addr1 : addr0;
    selWdata     = gnt1 ? wdata1 : wdata0;
    newTag.valid = anyGnt & ~selWr;
    newTag.owner = winner;
  end

  // Memory command register; address and data hold through idle cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      last      <= 1'b1;
    end else begin
      mem_en <= anyGnt;
      mem_wr <= anyGnt & selWr;
      if (anyGnt) begin
        mem_addr  <= selAddr;
        mem_wdata <= selWdata;
        last      <= winner;
      end
    end
  end

  // Tag shift register: one entry per cycle keeps returns aligned with the fixed memory latency.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tagPipe <= '0;
    end else begin
      tagPipe <= {tagPipe[TAG_DEPTH-2:0], newTag};
    end
  end

  assign retTag = tagPipe[MEM_LAT];

  // Read return: capture memory data for the owner; the other requester's data holds.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= retTag.valid & ~retTag.owner;
      rvalid1 <= retTag.valid & retTag.owner;
      if (retTag.valid && !retTag.owner) begin
        rdata0 <= mem_rdata;
      end
      if (retTag.valid && retTag.owner) begin
        rdata1 <= mem_rdata;
      end
    end
  end

  gntOneHot: assert property (@(posedge clock) disable iff (reset) !(gnt0 && gnt1));
  gntNeedsReq: assert property (@(posedge clock) disable iff (reset) (!gnt0 || req0) && (!gnt1 || req1));

endmodule

// File: tb/tb_vsa_dmem_arbiter.sv
// Bench for vsa_dmem_arbiter: two instances (MEM_LAT 1 and 3) on shared stimulus, each with its own memory,
// directed scenarios plus a randomized run checked against a queue-based reference model.
module tb_vsa_dmem_arbiter;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 5;

  typedef struct {
    int            gc;
    int            owner;
    logic [DW-1:0] data;
  } ret_t;

  logic          clock;
  logic          reset;
  logic          req0, wr0, req1, wr1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;

  logic          gnt0V [2];
  logic          gnt1V [2];
  logic          rvalid0V [2];
  logic          rvalid1V [2];
  logic          memEnV [2];
  logic          memWrV [2];
  logic [DW-1:0] rdata0V [2];
  logic [DW-1:0] rdata1V [2];
  logic [AW-1:0] memAddrV [2];
  logic [DW-1:0] memWdataV [2];
  logic [DW-1:0] memRdataV [2];

  logic          ldEn;
  logic [AW-1:0] ldAddr;
  logic [DW-1:0] ldData;
  logic [DW-1:0] refMem [32];

  int checks = 0;
  int failures = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int latOf(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gDut
    localparam int unsigned LAT = (g == 0) ? 1 : 3;
    logic [DW-1:0] mem [32];
    logic [DW-1:0] pipe [3];

    vsa_dmem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) uDut (
      .clock(clock), .reset(reset),
      .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0),
      .gnt0(gnt0V[g]), .rvalid0(rvalid0V[g]), .rdata0(rdata0V[g]),
      .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
      .gnt1(gnt1V[g]), .rvalid1(rvalid1V[g]), .rdata1(rdata1V[g]),
      .mem_en(memEnV[g]), .mem_wr(memWrV[g]), .mem_addr(memAddrV[g]),
      .mem_wdata(memWdataV[g]), .mem_rdata(memRdataV[g])
    );

    // Single-ported memory with a fixed read latency of LAT cycles
    always @(posedge clock) begin
      if (ldEn) mem[ldAddr] <= ldData;
      else if (memEnV[g] && memWrV[g]) mem[memAddrV[g]] <= memWdataV[g];
      pipe[0] <= (memEnV[g] && !memWrV[g]) ? mem[memAddrV[g]] : '0;
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign memRdataV[g] = pipe[LAT-1];
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic clearInputs();
    req0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
  endtask

  task automatic doReset();
    @(posedge clock); #1;
    clearInputs();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic preload(input bit rnd);
    @(posedge clock); #1;
    ldEn = 1'b1;
    for (int a = 0; a < 32; a++) begin
      ldAddr = AW'(a);
      ldData = rnd ? DW'($urandom) : DW'(a + 12);
      refMem[a] = ldData;
      @(posedge clock); #1;
    end
    ldEn = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clock); #1;
    req0 = 1'b1; req1 = 1'b1; reset = 1'b1;
    #2;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({memEnV[k], memWrV[k], rvalid0V[k], rvalid1V[k]} !== 4'b0000 || memAddrV[k] !== '0 ||
          memWdataV[k] !== '0 || rdata0V[k] !== '0 || rdata1V[k] !== '0) begin
        failures++;
        $display("FAIL reset_outputs[%0d] en=%b wr=%b addr=%0d wd=%0d rv=%b%b rd=%0d/%0d required all 0", k,
                 memEnV[k], memWrV[k], memAddrV[k], memWdataV[k], rvalid0V[k], rvalid1V[k], rdata0V[k], rdata1V[k]);
      end
    end
    @(posedge clock); #1;
    clearInputs();
    reset = 1'b0;
    @(posedge clock); #1;
    req0 = 1'b1; req1 = 1'b1;
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (gnt0V[k] !== 1'b1 || gnt1V[k] !== 1'b0) begin
        failures++;
        $display("FAIL reset_first_tie[%0d] gnt0=%b gnt1=%b required 1/0", k, gnt0V[k], gnt1V[k]);
      end
    end
    @(posedge clock); #1;
    clearInputs();
  endtask

  task automatic test_single_read();
    doReset();
    @(posedge clock); #1;
    req0 = 1'b1; wr0 = 1'b0; addr0 = AW'(9);
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (gnt0V[k] !== 1'b1 || gnt1V[k] !== 1'b0) begin
        failures++;
        $display("FAIL single_gnt[%0d] gnt0=%b gnt1=%b required 1/0", k, gnt0V[k], gnt1V[k]);
      end
    end
    for (int c = 2; c <= 8; c++) begin
      @(posedge clock); #1;
      req0 = 1'b0;
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
        if (c == 2) begin
          checks++;
          if (memEnV[k] !== 1'b1 || memWrV[k] !== 1'b0 || memAddrV[k] !== AW'(9)) begin
            failures++;
            $display("FAIL single_cmd[%0d] en=%b wr=%b addr=%0d required 1/0/9", k, memEnV[k], memWrV[k], memAddrV[k]);
          end
        end
        checks++;
        if (rvalid0V[k] !== (c == 3 + latOf(k)) || rvalid1V[k] !== 1'b0) begin
          failures++;
          $display("FAIL single_rvalid[%0d] cycle %0d rv0=%b rv1=%b required %b/0", k, c, rvalid0V[k], rvalid1V[k], c == 3 + latOf(k));
        end
        if (c == 3 + latOf(k)) begin
          checks++;
          if (rdata0V[k] !== DW'(21)) begin
            failures++;
            $display("FAIL single_rdata[%0d] rdata0=%0d required 21", k, rdata0V[k]);
          end
        end
      end
    end
  endtask

  task automatic test_contention();
    doReset();
    for (int c = 1; c <= 10; c++) begin
      @(posedge clock); #1;
      req0 = (c <= 4); wr0 = 1'b0; addr0 = AW'(4);
      req1 = (c <= 4); wr1 = 1'b0; addr1 = AW'(7);
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
        int l;
        l = latOf(k);
        checks++;
        if (gnt0V[k] !== (c <= 4 && c % 2 == 1) || gnt1V[k] !== (c <= 4 && c % 2 == 0)) begin
          failures++;
          $display("FAIL contention_gnt[%0d] cycle %0d gnt0=%b gnt1=%b", k, c, gnt0V[k], gnt1V[k]);
        end
        checks++;
        if (memEnV[k] !== (c >= 2 && c <= 5) ||
            (c >= 2 && c <= 5 && memAddrV[k] !== ((c % 2 == 0) ? AW'(4) : AW'(7)))) begin
          failures++;
          $display("FAIL contention_cmd[%0d] cycle %0d en=%b addr=%0d", k, c, memEnV[k], memAddrV[k]);
        end
        checks++;
        if (rvalid0V[k] !== (c == 3 + l || c == 5 + l) || rvalid1V[k] !== (c == 4 + l || c == 6 + l)) begin
          failures++;
          $display("FAIL contention_rvalid[%0d] cycle %0d rv0=%b rv1=%b", k, c, rvalid0V[k], rvalid1V[k]);
        end
        if ((rvalid0V[k] && rdata0V[k] !== DW'(16)) || (rvalid1V[k] && rdata1V[k] !== DW'(19))) begin
          checks++;
          failures++;
          $display("FAIL contention_rdata[%0d] cycle %0d rdata0=%0d rdata1=%0d required 16/19", k, c, rdata0V[k], rdata1V[k]);
        end else if (rvalid0V[k] || rvalid1V[k]) begin
          checks++;
        end
      end
    end
  endtask

  task automatic test_write_then_read();
    doReset();
    for (int c = 1; c <= 9; c++) begin
      @(posedge clock); #1;
      req1 = (c == 1); wr1 = 1'b1; addr1 = AW'(3); wdata1 = DW'(17);
      req0 = (c == 2); wr0 = 1'b0; addr0 = AW'(3);
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (gnt1V[k] !== (c == 1) || gnt0V[k] !== (c == 2)) begin
          failures++;
          $display("FAIL wr_rd_gnt[%0d] cycle %0d gnt0=%b gnt1=%b", k, c, gnt0V[k], gnt1V[k]);
        end
        checks++;
        if (memEnV[k] !== (c == 2 || c == 3) || memWrV[k] !== (c == 2) ||
            (c == 2 && (memAddrV[k] !== AW'(3) || memWdataV[k] !== DW'(17))) ||
            (c == 3 && memAddrV[k] !== AW'(3))) begin
          failures++;
          $display("FAIL wr_rd_cmd[%0d] cycle %0d en=%b wr=%b addr=%0d wd=%0d", k, c, memEnV[k], memWrV[k], memAddrV[k], memWdataV[k]);
        end
        checks++;
        if (rvalid0V[k] !== (c == 4 + latOf(k)) || rvalid1V[k] !== 1'b0 ||
            (c == 4 + latOf(k) && rdata0V[k] !== DW'(17))) begin
          failures++;
          $display("FAIL wr_rd_return[%0d] cycle %0d rv0=%b rv1=%b rdata0=%0d required rdata0=17", k, c, rvalid0V[k], rvalid1V[k], rdata0V[k]);
        end
      end
    end
  endtask

  task automatic test_latency();
    logic [DW-1:0] expD [3];
    expD[0] = DW'(13); expD[1] = DW'(14); expD[2] = DW'(17);
    doReset();
    for (int c = 1; c <= 10; c++) begin
      @(posedge clock); #1;
      req1 = (c <= 3); wr1 = 1'b0; addr1 = AW'(c);
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
        int l;
        l = latOf(k);
        checks++;
        if (gnt1V[k] !== (c <= 3) || gnt0V[k] !== 1'b0) begin
          failures++;
          $display("FAIL latency_gnt[%0d] cycle %0d gnt0=%b gnt1=%b", k, c, gnt0V[k], gnt1V[k]);
        end
        checks++;
        if (rvalid1V[k] !== (c >= 3 + l && c <= 5 + l) || rvalid0V[k] !== 1'b0 ||
            (c >= 3 + l && c <= 5 + l && rdata1V[k] !== expD[c-3-l])) begin
          failures++;
          $display("FAIL latency_return[%0d] cycle %0d rv1=%b rdata1=%0d rv0=%b", k, c, rvalid1V[k], rdata1V[k], rvalid0V[k]);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    doReset();
    @(posedge clock); #1;
    req0 = 1'b1; wr0 = 1'b0; addr0 = AW'(5);
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (gnt0V[k] !== 1'b1) begin
        failures++;
        $display("FAIL midflight_gnt[%0d] gnt0=%b required 1", k, gnt0V[k]);
      end
    end
    @(posedge clock); #1;
    req0 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (memEnV[k] !== 1'b1) begin
        failures++;
        $display("FAIL midflight_issue[%0d] en=%b required 1", k, memEnV[k]);
      end
    end
    #1 reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (memEnV[k] !== 1'b0 || memWrV[k] !== 1'b0) begin
        failures++;
        $display("FAIL midflight_en_drop[%0d] en=%b wr=%b required 0/0", k, memEnV[k], memWrV[k]);
      end
    end
    @(posedge clock); #1;
    reset = 1'b0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (rvalid0V[k] !== 1'b0 || rvalid1V[k] !== 1'b0 || rdata0V[k] !== '0) begin
          failures++;
          $display("FAIL midflight_no_return[%0d] step %0d rv0=%b rv1=%b rdata0=%0d", k, c, rvalid0V[k], rvalid1V[k], rdata0V[k]);
        end
      end
      @(posedge clock); #1;
    end
    req0 = 1'b1; wr0 = 1'b0; addr0 = AW'(5);
    req1 = 1'b1; wr1 = 1'b0; addr1 = AW'(6);
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (gnt0V[k] !== 1'b1 || gnt1V[k] !== 1'b0) begin
        failures++;
        $display("FAIL midflight_tie[%0d] gnt0=%b gnt1=%b required 1/0", k, gnt0V[k], gnt1V[k]);
      end
    end
    @(posedge clock); #1;
    clearInputs();
  endtask

  task automatic test_idle();
    repeat (6) @(posedge clock);
    #1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (memEnV[k] !== 1'b0 || memWrV[k] !== 1'b0 || memAddrV[k] !== AW'(5) || memWdataV[k] !== '0) begin
          failures++;
          $display("FAIL idle_cmd[%0d] step %0d en=%b wr=%b addr=%0d wd=%0d required 0/0/5/0", k, c, memEnV[k], memWrV[k], memAddrV[k], memWdataV[k]);
        end
        checks++;
        if (rvalid0V[k] !== 1'b0 || rvalid1V[k] !== 1'b0 || rdata0V[k] !== DW'(17) || rdata1V[k] !== '0) begin
          failures++;
          $display("FAIL idle_hold[%0d] step %0d rv=%b%b rdata0=%0d rdata1=%0d required 17/0", k, c, rvalid0V[k], rvalid1V[k], rdata0V[k], rdata1V[k]);
        end
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_random();
    ret_t          rq[$];
    int            head [2];
    logic [DW-1:0] hold0 [2];
    logic [DW-1:0] hold1 [2];
    int            mLast, win, n;
    bit            pend0, pend1, rv0, rv1;
    logic          eEn, eWr, wWr;
    logic [AW-1:0] eAddr, wAddr;
    logic [DW-1:0] eWd, wData;
    n = 300;
    doReset();
    preload(1'b1);
    mLast = 1; eEn = 1'b0; eWr = 1'b0; eAddr = '0; eWd = '0; pend0 = 1'b0; pend1 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      head[k] = 0; hold0[k] = '0; hold1[k] = '0;
    end
    for (int c = 0; c < n; c++) begin
      @(posedge clock); #1;
      if (c >= n - 8) begin
        req0 = 1'b0; req1 = 1'b0;
      end else begin
        if (!pend0) begin
          req0 = ($urandom_range(0, 3) != 0); wr0 = ($urandom_range(0, 2) == 0);
          addr0 = AW'($urandom_range(0, 7)); wdata0 = DW'($urandom);
        end
        if (!pend1) begin
          req1 = ($urandom_range(0, 3) != 0); wr1 = ($urandom_range(0, 2) == 0);
          addr1 = AW'($urandom_range(0, 7)); wdata1 = DW'($urandom);
        end
      end
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (memEnV[k] !== eEn || memWrV[k] !== eWr || memAddrV[k] !== eAddr || memWdataV[k] !== eWd) begin
          failures++;
          $display("FAIL random_cmd[%0d] cycle %0d got en=%b wr=%b addr=%0d wd=%0d required %b/%b/%0d/%0d",
                   k, c, memEnV[k], memWrV[k], memAddrV[k], memWdataV[k], eEn, eWr, eAddr, eWd);
        end
        rv0 = 1'b0; rv1 = 1'b0;
        if (head[k] < rq.size()) begin
          if (rq[head[k]].gc + 2 + latOf(k) == c) begin
            if (rq[head[k]].owner == 0) begin rv0 = 1'b1; hold0[k] = rq[head[k]].data; end
            else begin rv1 = 1'b1; hold1[k] = rq[head[k]].data; end
            head[k]++;
          end
        end
        checks++;
        if (rvalid0V[k] !== rv0 || rvalid1V[k] !== rv1 || rdata0V[k] !== hold0[k] || rdata1V[k] !== hold1[k]) begin
          failures++;
          $display("FAIL random_return[%0d] cycle %0d got rv=%b%b rd=%0d/%0d required rv=%b%b rd=%0d/%0d",
                   k, c, rvalid0V[k], rvalid1V[k], rdata0V[k], rdata1V[k], rv0, rv1, hold0[k], hold1[k]);
        end
      end
      if (req0 && req1) win = (mLast == 0) ? 1 : 0;
      else if (req0)    win = 0;
      else if (req1)    win = 1;
      else              win = -1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (gnt0V[k] !== (win == 0) || gnt1V[k] !== (win == 1)) begin
          failures++;
          $display("FAIL random_gnt[%0d] cycle %0d got %b%b required winner %0d", k, c, gnt0V[k], gnt1V[k], win);
        end
      end
      if (win >= 0) begin
        wWr   = (win == 1) ? wr1 : wr0;
        wAddr = (win == 1) ? addr1 : addr0;
        wData = (win == 1) ? wdata1 : wdata0;
        eEn = 1'b1; eWr = wWr; eAddr = wAddr; eWd = wData; mLast = win;
        if (wWr) refMem[wAddr] = wData;
        else rq.push_back('{gc: c, owner: win, data: refMem[wAddr]});
      end else begin
        eEn = 1'b0; eWr = 1'b0;
      end
      pend0 = req0 && (win != 0);
      pend1 = req1 && (win != 1);
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (head[k] != rq.size()) begin
        failures++;
        $display("FAIL random_drain[%0d] returns seen=%0d required %0d", k, head[k], rq.size());
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    ldEn = 1'b0; ldAddr = '0; ldData = '0;
    clearInputs();
    test_reset();
    preload(1'b0);
    test_single_read();
    test_contention();
    test_write_then_read();
    test_latency();
    test_reset_midflight();
    test_idle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
